int_sequencer: RTL and testbench
================================

Name: int_sequencer

Overview:
Interrupt and reset sequencer for the 6502 core. It detects RESET, NMI and IRQ, and drives the rstg/intg flags that force the fetched opcode to 00 (BRK). It then runs the shared 7-cycle BRK/IRQ/NMI/RESET sequence: dummy read, three stack pushes, vector fetch. During that sequence it overrides the core's address, write and register-update controls. Software BRK uses the same sequence with B=1 and a PC increment.

Parameters:
NMI_VEC, 16'hFFFA, NMI vector low-byte address
RST_VEC, 16'hFFFC, RESET vector low-byte address
IRQ_VEC, 16'hFFFE, IRQ/BRK vector low-byte address
STACK_PAGE, 8'h01, high byte of stack addresses

Ports:
clk_m1  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rdy  in  1  core ready; low stalls read cycles only
sync  in  1  core is in an opcode-fetch cycle
brk_i  in  1  decoded ir==00 in the cycle after sync (software BRK)
nmi_n  in  1  NMI request, active-low, falling-edge triggered
irq_n  in  1  IRQ request, active-low, level
p_i  in  8  status register (bit 2 = I)
s_i  in  8  stack pointer
rstg  out  1  reset sequence in progress
intg  out  1  hardware-interrupt sequence in progress (IRQ or NMI)
busy  out  1  any sequence active (including BRK)
addr_o  out  16  address override
addr_oe  out  1  addr_o replaces the PC address
we_o  out  1  write strobe for the push cycles
push_sel  out  2  data-out source: 0=PCH, 1=PCL, 2=P
b_flag_o  out  1  B bit value for the P push
pc_inc_o  out  1  increment PC (BRK dummy cycle only)
s_dec_o  out  1  decrement S
set_i_o  out  1  set the I flag
pcl_ld_o  out  1  load PCL from the data bus
pch_ld_o  out  1  load PCH from the data bus

Behaviour:
- States: IDLE, DUMMY, PCH, PCL, P, VLO, VHI.
- Reset state and output values while rst=1:
  - state=IDLE, rst_pend=1, nmi_pend=0, nmi_prev=1.
  - All outputs 0 except rstg=1.
  - rst mid-sequence aborts that sequence immediately.
- NMI edge detection: nmi_prev registers nmi_n every cycle; nmi_prev=1 && nmi_n=0 sets nmi_pend. nmi_pend clears in the VLO cycle of any sequence that uses NMI_VEC.
- IRQ request: irq_req = !irq_n && !p_i[2], evaluated combinationally at the sync cycle.
- Entry, when IDLE && sync && rdy, in priority order:
  - rst_pend → source RST, rstg=1.
  - nmi_pend → source NMI, intg=1.
  - irq_req → source IRQ, intg=1.
  - The source is latched and the next state is DUMMY.
- Software BRK: IDLE && brk_i with no hardware entry → source BRK, state=PCH; the BRK fetch cycle itself serves as DUMMY. pc_inc_o=1 in the brk_i cycle (skips the signature byte). Hardware sources never assert pc_inc_o.
- Per-state actions, with S taken from s_i; each state advances one cycle:
  - DUMMY: addr_oe=0 (PC read); no PC increment.
  - PCH: addr_o={STACK_PAGE,S}, addr_oe=1, push_sel=0, s_dec_o=1.
  - PCL: addr_o={STACK_PAGE,S}, addr_oe=1, push_sel=1, s_dec_o=1.
  - P: addr_o={STACK_PAGE,S}, addr_oe=1, push_sel=2, s_dec_o=1, b_flag_o = (source==BRK).
  - In PCH/PCL/P, we_o=1 except for source RST (we_o=0; S still decrements).
  - VLO: addr_o = vector, addr_oe=1, pcl_ld_o=1, set_i_o=1.
  - VHI: addr_o = vector+1, addr_oe=1, pch_ld_o=1. Next state is IDLE; rstg and intg clear on that transition.
- Total 7 cycles from the sync cycle to the VHI cycle inclusive; the first opcode fetch follows.
- Vector selection: RST→RST_VEC; NMI→NMI_VEC; IRQ or BRK→IRQ_VEC, unless nmi_pend=1 at VLO (NMI hijack), in which case NMI_VEC is used for both VLO and VHI and nmi_pend clears. Selection is frozen from VLO onward.
- rdy=0:
  - Holds state in DUMMY, VLO and VHI; outputs stay stable.
  - PCH, PCL and P (writes) advance regardless.
  - rdy=0 in IDLE blocks entry.
- Simultaneous events:
  - An NMI edge in the same cycle as IRQ entry latches nmi_pend and hijacks at VLO.
  - An IRQ asserted during a sequence is re-evaluated only at the next IDLE sync, where the I flag (set in VLO) masks it.
- S wraps naturally (8'h00 − 1 = 8'hFF); no overflow detection.

Decomposition:
- Shared package cpu6502_pkg:
  - Source enum (SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK).
  - Sequencer state enum.
  - push_sel encodings.
  - Vector constants (also exported to the top level).
- One sub-module: nmi_edge_det (registered falling-edge detector plus pending latch with clear).

Test Plan:
- RESET: rst=1 for 2 cycles, s_i=8'hFD, then rst=0 with sync=1 → DUMMY; PCH/PCL/P present addr_o 01FD, 01FC, 01FB with we_o=0; VLO addr_o=FFFC, VHI addr_o=FFFD; rstg falls after VHI; 7 cycles total.
- IRQ: p_i=8'h00, irq_n=0 at a sync cycle, s_i=8'hFF → writes at 01FF/01FE/01FD with push_sel 0,1,2 and b_flag_o=0; VLO addr_o=FFFE with set_i_o=1; pc_inc_o never asserted.
- IRQ masked: p_i=8'h04, irq_n=0 held for 20 cycles with sync pulses → busy stays 0, no addr_oe.
- BRK: brk_i=1 → pc_inc_o=1 for one cycle, P push has b_flag_o=1, vector FFFE/FFFF.
- NMI hijack: start IRQ entry; drive nmi_n 1→0 during the PCL state → VLO addr_o=FFFA, VHI addr_o=FFFB; nmi_pend cleared; no second NMI sequence follows.
- Stall and abort:
  - rdy=0 for 3 cycles in VLO → addr_o holds FFFE for 4 cycles; rdy=0 during PCH → state still advances.
  - rst=1 asserted in state P → next cycle IDLE with rstg=1 and all other outputs 0.

Source files
------------

// File: rtl/cpu6502_pkg.sv
// Shared 6502 definitions: interrupt sources, sequencer states, push selects, vectors.
package cpu6502_pkg;

  typedef enum logic [1:0] {
    SRC_RST,
    SRC_NMI,
    SRC_IRQ,
    SRC_BRK
  } int_src_e;

  typedef enum logic [2:0] {
    StIdle,
    StDummy,
    StPch,
    StPcl,
    StP,
    StVlo,
    StVhi
  } seq_state_e;

  localparam logic [1:0] PUSH_PCH = 2'd0;
  localparam logic [1:0] PUSH_PCL = 2'd1;
  localparam logic [1:0] PUSH_P   = 2'd2;

  localparam logic [15:0] NMI_VEC_ADDR    = 16'hFFFA;
  localparam logic [15:0] RST_VEC_ADDR    = 16'hFFFC;
  localparam logic [15:0] IRQ_VEC_ADDR    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE_ADDR = 8'h01;

endpackage

// File: rtl/int_sequencer_if.sv
// Core <-> interrupt sequencer signal bundle.
interface int_sequencer_if;
  logic        rdy;
  logic        sync;
  logic        brk_i;
  logic        nmi_n;
  logic        irq_n;
  logic [7:0]  p_i;
  logic [7:0]  s_i;
  logic        rstg;
  logic        intg;
  logic        busy;
  logic [15:0] addr_o;
  logic        addr_oe;
  logic        we_o;
  logic [1:0]  push_sel;
  logic        b_flag_o;
  logic        pc_inc_o;
  logic        s_dec_o;
  logic        set_i_o;
  logic        pcl_ld_o;
  logic        pch_ld_o;

  // Core side: drives status and requests, consumes overrides.
  modport master (
    output rdy, sync, brk_i, nmi_n, irq_n, p_i, s_i,
    input  rstg, intg, busy, addr_o, addr_oe, we_o, push_sel, b_flag_o,
           pc_inc_o, s_dec_o, set_i_o, pcl_ld_o, pch_ld_o
  );

  // Sequencer side.
  modport slave (
    input  rdy, sync, brk_i, nmi_n, irq_n, p_i, s_i,
    output rstg, intg, busy, addr_o, addr_oe, we_o, push_sel, b_flag_o,
           pc_inc_o, s_dec_o, set_i_o, pcl_ld_o, pch_ld_o
  );
endinterface

// File: rtl/nmi_edge_det.sv
// NMI falling-edge detector with a pending latch; a new edge wins over a same-cycle clear.
module nmi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic clr,
  output logic pend
);

  logic nmi_prev_q;
  logic pend_q;
  logic pend_d;

  // Set on a 1->0 transition of nmi_n, hold until cleared.
  always_comb begin
    pend_d = (nmi_prev_q && !nmi_n) || (pend_q && !clr);
  end

  // Edge history and pending state.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev_q <= 1'b1;
      pend_q     <= 1'b0;
    end else begin
      nmi_prev_q <= nmi_n;
      pend_q     <= pend_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/int_sequencer.sv
// Interrupt/reset sequencer: runs the shared 7-cycle BRK/IRQ/NMI/RESET sequence and
// overrides the core's address, write and register-load controls while it runs.
module int_sequencer
  import cpu6502_pkg::*;
#(
  parameter logic [15:0] NMI_VEC    = NMI_VEC_ADDR,
  parameter logic [15:0] RST_VEC    = RST_VEC_ADDR,
  parameter logic [15:0] IRQ_VEC    = IRQ_VEC_ADDR,
  parameter logic [7:0]  STACK_PAGE = STACK_PAGE_ADDR
) (
  input logic            clk_m1,
  input logic            rst,
  int_sequencer_if.slave bus
);

  seq_state_e  state_q, state_d;
  int_src_e    src_q, src_d, entry_src;
  logic        rst_pend_q, rst_pend_d;
  logic [15:0] vec_q, vec_sel, vec_cur;
  logic        vec_frz_q, vec_frz_d;
  logic        nmi_pend, nmi_clr;
  logic        irq_req, idle, hw_entry, sw_entry, vlo_first;
  logic [15:0] stack_addr;
  logic        unused_p;

  assign unused_p = ^{bus.p_i[7:3], bus.p_i[1:0]};

  nmi_edge_det u_nmi (
    .clk   (clk_m1),
    .rst   (rst),
    .nmi_n (bus.nmi_n),
    .clr   (nmi_clr),
    .pend  (nmi_pend)
  );

  // Entry decode, vector selection and next-state logic.
  always_comb begin
    irq_req    = !bus.irq_n && !bus.p_i[2];
    idle       = (state_q == StIdle);
    hw_entry   = idle && bus.sync && bus.rdy && (rst_pend_q || nmi_pend || irq_req);
    sw_entry   = idle && bus.brk_i && !hw_entry;
    stack_addr = {STACK_PAGE, bus.s_i};

    entry_src = SRC_IRQ;
    if (rst_pend_q)    entry_src = SRC_RST;
    else if (nmi_pend) entry_src = SRC_NMI;

    // A pending NMI at the first VLO cycle hijacks an IRQ/BRK sequence.
    vec_sel = IRQ_VEC;
    unique case (src_q)
      SRC_RST: vec_sel = RST_VEC;
      SRC_NMI: vec_sel = NMI_VEC;
      default: vec_sel = nmi_pend ? NMI_VEC : IRQ_VEC;
    endcase

    vlo_first = (state_q == StVlo) && !vec_frz_q;
    vec_cur   = vlo_first ? vec_sel : vec_q;
    nmi_clr   = vlo_first && (vec_sel == NMI_VEC);

    state_d    = state_q;
    src_d      = src_q;
    rst_pend_d = rst_pend_q && !hw_entry;
    unique case (state_q)
      StIdle: begin
        if (hw_entry) begin
          state_d = StDummy;
          src_d   = entry_src;
        end else if (sw_entry) begin
          state_d = StPch;
          src_d   = SRC_BRK;
        end
      end
      StDummy: if (bus.rdy) state_d = StPch;
      StPch:   state_d = StPcl;
      StPcl:   state_d = StP;
      StP:     state_d = StVlo;
      StVlo:   if (bus.rdy) state_d = StVhi;
      StVhi:   if (bus.rdy) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    vec_frz_d = ((state_q == StVlo) || (state_q == StVhi)) && (state_d != StIdle);
  end

  // Sequencer state, latched source and frozen vector.
  always_ff @(posedge clk_m1) begin
    if (rst) begin
      state_q    <= StIdle;
      src_q      <= SRC_RST;
      rst_pend_q <= 1'b1;
      vec_q      <= RST_VEC;
      vec_frz_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      rst_pend_q <= rst_pend_d;
      vec_q      <= vec_cur;
      vec_frz_q  <= vec_frz_d;
    end
  end

  // Per-state overrides; reset forces everything quiet except rstg.
  always_comb begin
    bus.addr_o   = 16'h0000;
    bus.addr_oe  = 1'b0;
    bus.we_o     = 1'b0;
    bus.push_sel = PUSH_PCH;
    bus.b_flag_o = 1'b0;
    bus.s_dec_o  = 1'b0;
    bus.set_i_o  = 1'b0;
    bus.pcl_ld_o = 1'b0;
    bus.pch_ld_o = 1'b0;
    bus.pc_inc_o = sw_entry;
    bus.busy     = !idle;
    bus.rstg     = rst_pend_q || (!idle && (src_q == SRC_RST));
    bus.intg     = (hw_entry && !rst_pend_q) ||
                   (!idle && ((src_q == SRC_NMI) || (src_q == SRC_IRQ)));
    unique case (state_q)
      StPch, StPcl, StP: begin
        bus.addr_o  = stack_addr;
        bus.addr_oe = 1'b1;
        bus.we_o    = (src_q != SRC_RST);
        bus.s_dec_o = 1'b1;
        if (state_q == StPcl) bus.push_sel = PUSH_PCL;
        if (state_q == StP) begin
          bus.push_sel = PUSH_P;
          bus.b_flag_o = (src_q == SRC_BRK);
        end
      end
      StVlo: begin
        bus.addr_o   = vec_cur;
        bus.addr_oe  = 1'b1;
        bus.pcl_ld_o = 1'b1;
        bus.set_i_o  = 1'b1;
      end
      StVhi: begin
        bus.addr_o   = vec_q + 16'd1;
        bus.addr_oe  = 1'b1;
        bus.pch_ld_o = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      bus.addr_o   = 16'h0000;
      bus.addr_oe  = 1'b0;
      bus.we_o     = 1'b0;
      bus.push_sel = PUSH_PCH;
      bus.b_flag_o = 1'b0;
      bus.s_dec_o  = 1'b0;
      bus.set_i_o  = 1'b0;
      bus.pcl_ld_o = 1'b0;
      bus.pch_ld_o = 1'b0;
      bus.pc_inc_o = 1'b0;
      bus.busy     = 1'b0;
      bus.intg     = 1'b0;
      bus.rstg     = 1'b1;
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer; the bench acts as the core, decrementing S on s_dec_o.
module tb_int_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  int_sequencer_if bus ();

  int_sequencer dut (
    .clk_m1 (clk),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // {rstg,intg,busy,addr_oe,addr_o,we_o,push_sel,b_flag,pc_inc,s_dec,set_i,pcl_ld,pch_ld}
  function automatic logic [28:0] pk(input logic rg, input logic ig, input logic bz,
                                     input logic oe, input logic [15:0] a, input logic we,
                                     input logic [1:0] ps, input logic b, input logic pci,
                                     input logic sd, input logic si, input logic pl,
                                     input logic ph);
    return {rg, ig, bz, oe, a, we, ps, b, pci, sd, si, pl, ph};
  endfunction

  function automatic logic [28:0] obs();
    return {bus.rstg, bus.intg, bus.busy, bus.addr_oe, bus.addr_o, bus.we_o, bus.push_sel,
            bus.b_flag_o, bus.pc_inc_o, bus.s_dec_o, bus.set_i_o, bus.pcl_ld_o, bus.pch_ld_o};
  endfunction

  task automatic chk_out(input string tag, input logic [28:0] exp);
    #1;
    check(tag, {3'b000, obs()}, {3'b000, exp});
  endtask

  task automatic step();
    logic dec;
    dec = bus.s_dec_o;
    @(posedge clk);
    #1;
    if (dec) bus.s_i = bus.s_i - 8'd1;
  endtask

  // Checks DUMMY (optional) through VHI and the IDLE cycle that follows.
  task automatic run_seq(input string tag, input logic rg, input logic ig, input bit dummy,
                         input logic b, input logic [7:0] s0, input logic [15:0] vec,
                         input bit nmi_at_pcl);
    logic we;
    we = !rg;
    if (dummy) begin
      chk_out({tag, "_dummy"}, pk(rg, ig, 1, 0, 16'h0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
      step();
    end
    chk_out({tag, "_pch"}, pk(rg, ig, 1, 1, {8'h01, s0}, we, 2'd0, 0, 0, 1, 0, 0, 0));
    step();
    if (nmi_at_pcl) bus.nmi_n = 1'b0;
    chk_out({tag, "_pcl"}, pk(rg, ig, 1, 1, {8'h01, s0 - 8'd1}, we, 2'd1, 0, 0, 1, 0, 0, 0));
    step();
    chk_out({tag, "_p"}, pk(rg, ig, 1, 1, {8'h01, s0 - 8'd2}, we, 2'd2, b, 0, 1, 0, 0, 0));
    step();
    chk_out({tag, "_vlo"}, pk(rg, ig, 1, 1, vec, 0, 2'd0, 0, 0, 0, 1, 1, 0));
    step();
    chk_out({tag, "_vhi"}, pk(rg, ig, 1, 1, vec + 16'd1, 0, 2'd0, 0, 0, 0, 0, 0, 1));
    step();
    chk_out({tag, "_idle"}, pk(0, 0, 0, 0, 16'h0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic irq_entry(input string tag, input logic [7:0] s0);
    bus.p_i   = 8'h00;
    bus.irq_n = 1'b0;
    bus.sync  = 1'b1;
    bus.s_i   = s0;
    chk_out({tag, "_entry"}, pk(0, 1, 0, 0, 16'h0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    step();
    bus.sync  = 1'b0;
    bus.irq_n = 1'b1;
  endtask

  localparam logic [28:0] Quiet = 29'h0;

  initial begin
    rst       = 1'b1;
    bus.rdy   = 1'b1;
    bus.sync  = 1'b0;
    bus.brk_i = 1'b0;
    bus.nmi_n = 1'b1;
    bus.irq_n = 1'b1;
    bus.p_i   = 8'h00;
    bus.s_i   = 8'hFD;
    step();
    step();
    chk_out("reset_state", pk(1, 0, 0, 0, 16'h0, 0, 2'd0, 0, 0, 0, 0, 0, 0));

    // RESET: no writes, S still decrements, vector FFFC/FFFD.
    rst      = 1'b0;
    bus.sync = 1'b1;
    chk_out("rst_entry", pk(1, 0, 0, 0, 16'h0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    step();
    bus.sync = 1'b0;
    run_seq("rst", 1, 0, 1, 0, 8'hFD, 16'hFFFC, 0);

    // IRQ with I clear.
    irq_entry("irq", 8'hFF);
    run_seq("irq", 0, 1, 1, 0, 8'hFF, 16'hFFFE, 0);

    // IRQ masked by I: never enters.
    bus.p_i   = 8'h04;
    bus.irq_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.sync = (i % 4 == 0);
      chk_out("irq_masked", Quiet);
      step();
    end
    bus.sync  = 1'b0;
    bus.irq_n = 1'b1;
    bus.p_i   = 8'h00;

    // Software BRK, S wrapping through 00 -> FF.
    bus.s_i   = 8'h01;
    bus.brk_i = 1'b1;
    chk_out("brk_pcinc", pk(0, 0, 0, 0, 16'h0, 0, 2'd0, 0, 1, 0, 0, 0, 0));
    step();
    bus.brk_i = 1'b0;
    run_seq("brk", 0, 0, 0, 1, 8'h01, 16'hFFFE, 0);

    // NMI edge during PCL hijacks the IRQ vector; no second NMI sequence afterwards.
    irq_entry("hijack", 8'hFF);
    run_seq("hijack", 0, 1, 1, 0, 8'hFF, 16'hFFFA, 1);
    bus.sync = 1'b1;
    chk_out("no_renmi_sync", Quiet);
    step();
    bus.sync = 1'b0;
    chk_out("no_renmi_after", Quiet);
    bus.nmi_n = 1'b1;
    step();
    step();

    // Stalls: PCH advances with rdy=0, VLO holds for 3 rdy=0 cycles.
    irq_entry("stall", 8'hFF);
    chk_out("stall_dummy", pk(0, 1, 1, 0, 16'h0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    step();
    bus.rdy = 1'b0;
    chk_out("stall_pch", pk(0, 1, 1, 1, 16'h01FF, 1, 2'd0, 0, 0, 1, 0, 0, 0));
    step();
    bus.rdy = 1'b1;
    chk_out("stall_pcl", pk(0, 1, 1, 1, 16'h01FE, 1, 2'd1, 0, 0, 1, 0, 0, 0));
    step();
    chk_out("stall_p", pk(0, 1, 1, 1, 16'h01FD, 1, 2'd2, 0, 0, 1, 0, 0, 0));
    step();
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out("stall_vlo_hold", pk(0, 1, 1, 1, 16'hFFFE, 0, 2'd0, 0, 0, 0, 1, 1, 0));
      step();
    end
    bus.rdy = 1'b1;
    chk_out("stall_vlo_go", pk(0, 1, 1, 1, 16'hFFFE, 0, 2'd0, 0, 0, 0, 1, 1, 0));
    step();
    chk_out("stall_vhi", pk(0, 1, 1, 1, 16'hFFFF, 0, 2'd0, 0, 0, 0, 0, 0, 1));
    step();
    chk_out("stall_idle", Quiet);

    // Reset in P aborts the sequence.
    irq_entry("abort", 8'hFF);
    step();
    step();
    step();
    chk_out("abort_p", pk(0, 1, 1, 1, 16'h01FD, 1, 2'd2, 0, 0, 1, 0, 0, 0));
    rst = 1'b1;
    chk_out("abort_in_rst", pk(1, 0, 0, 0, 16'h0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    chk_out("abort_idle", pk(1, 0, 0, 0, 16'h0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
    step();
    chk_out("abort_stays_idle", pk(1, 0, 0, 0, 16'h0, 0, 2'd0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
